// File: rtl/race_seq_pkg.sv
// Shared types and helpers for the race-logic gamma-cycle sequencer.
package race_seq_pkg;

    // Sequencer phases of one gamma cycle.
    typedef enum logic [1:0] {
        IDLE = 2'd0,
        SET  = 2'd1,
        RUN  = 2'd2,
        DONE = 2'd3
    } seq_state_t;

    // All-ones code that stands for "no spike" at a given time width.
    function automatic int inf_time(input int tw);
        return (1 << tw) - 1;
    endfunction

    // Level an edge line rests at before its spike arrives.
    function automatic logic edge_idle(input bit falling);
        return falling;
    endfunction

endpackage

// File: rtl/spike_edge_gen.sv
// One temporal input lane: holds its spike time and drives a sticky edge
// that goes active on the cycle the shared time base reaches that time.
module spike_edge_gen
    import race_seq_pkg::*;
#(
    parameter int TW      = 3,
    parameter bit FALLING = 1'b0
) (
    input  logic          aclk,
    input  logic          grst,
    input  logic          load,
    input  logic [TW-1:0] load_time,
    input  logic          clear,
    input  logic          arm,
    input  logic [TW-1:0] tcnt_next,
    output logic          edge_o
);

    localparam logic [TW-1:0] INF = TW'(inf_time(TW));

    logic [TW-1:0] time_reg;
    logic          fired_reg;

    // Latch the job's time and raise the edge one register stage ahead so it
    // is already active during the RUN cycle whose count equals that time.
    always_ff @(posedge aclk or negedge grst) begin
        if (!grst) begin
            time_reg  <= INF;
            fired_reg <= 1'b0;
        end else begin
            if (load) begin
                time_reg <= load_time;
            end
            if (clear) begin
                fired_reg <= 1'b0;
            end else if (arm && (tcnt_next == time_reg) && (time_reg != INF)) begin
                fired_reg <= 1'b1;
            end
        end
    end

    assign edge_o = fired_reg ^ edge_idle(FALLING);

endmodule

// File: rtl/race_gamma_sequencer.sv
// Runs one gamma cycle: clear the fabric, replay the input spike times as
// edges on a shared time base, and report when the fabric output fired.
module race_gamma_sequencer
    import race_seq_pkg::*;
#(
    parameter int N       = 2,
    parameter int TW      = 3,
    parameter bit FALLING = 1'b0
) (
    input  logic            aclk,
    input  logic            grst,
    input  logic            in_valid,
    output logic            in_ready,
    input  logic [N*TW-1:0] in_time,
    output logic            set,
    output logic [N-1:0]    edge_o,
    input  logic            q_i,
    output logic            out_valid,
    input  logic            out_ready,
    output logic [TW-1:0]   out_time,
    output logic            err
);

    localparam logic [TW-1:0] INF  = TW'(inf_time(TW));
    localparam logic [TW-1:0] LAST = INF - TW'(1);

    seq_state_t    state_reg, state_next;
    logic [TW-1:0] tcnt_reg, tcnt_next;
    logic [TW-1:0] cap_reg;
    logic          captured_reg;
    logic          err_reg;
    logic          q_active;
    logic          load;
    logic          arm;
    logic          clear;

    assign q_active = q_i ^ edge_idle(FALLING);

    // Next phase, time base and handshake outputs; tcnt only advances in RUN
    // and sits at zero otherwise so every job starts counting from 0.
    always_comb begin
        state_next = state_reg;
        tcnt_next  = '0;
        in_ready   = 1'b0;
        set        = 1'b0;
        out_valid  = 1'b0;
        case (state_reg)
            IDLE: begin
                in_ready = 1'b1;
                if (in_valid) begin
                    state_next = SET;
                end
            end
            SET: begin
                set        = 1'b1;
                state_next = RUN;
            end
            RUN: begin
                if (tcnt_reg == LAST) begin
                    state_next = DONE;
                end else begin
                    tcnt_next = tcnt_reg + TW'(1);
                end
            end
            DONE: begin
                out_valid = 1'b1;
                if (out_ready) begin
                    state_next = IDLE;
                end
            end
            default: state_next = IDLE;
        endcase
    end

    // Phase and time-base registers.
    always_ff @(posedge aclk or negedge grst) begin
        if (!grst) begin
            state_reg <= IDLE;
            tcnt_reg  <= '0;
        end else begin
            state_reg <= state_next;
            tcnt_reg  <= tcnt_next;
        end
    end

    // Fabric-not-cleared check during SET and first-edge capture during RUN;
    // both are dropped once the result has been handed off.
    always_ff @(posedge aclk or negedge grst) begin
        if (!grst) begin
            captured_reg <= 1'b0;
            cap_reg      <= INF;
            err_reg      <= 1'b0;
        end else begin
            case (state_reg)
                SET: begin
                    captured_reg <= 1'b0;
                    cap_reg      <= INF;
                    err_reg      <= q_active;
                end
                RUN: begin
                    if (!captured_reg && q_active) begin
                        captured_reg <= 1'b1;
                        cap_reg      <= tcnt_reg;
                    end
                end
                DONE: begin
                    if (out_ready) begin
                        captured_reg <= 1'b0;
                        cap_reg      <= INF;
                        err_reg      <= 1'b0;
                    end
                end
                default: ;
            endcase
        end
    end

    assign out_time = captured_reg ? cap_reg : INF;
    assign err      = err_reg;

    assign load  = (state_reg == IDLE) && in_valid;
    assign arm   = (state_next == RUN);
    assign clear = (state_reg == DONE) && out_ready;

    generate
        for (genvar gi = 0; gi < N; gi++) begin : g_lane
            spike_edge_gen #(
                .TW      (TW),
                .FALLING (FALLING)
            ) u_lane (
                .aclk      (aclk),
                .grst      (grst),
                .load      (load),
                .load_time (in_time[gi*TW +: TW]),
                .clear     (clear),
                .arm       (arm),
                .tcnt_next (tcnt_next),
                .edge_o    (edge_o[gi])
            );
        end
    endgenerate

endmodule

// File: tb/tb_race_gamma_sequencer.sv
// Bench: rising and falling sequencers driven side by side against a
// cycle-by-cycle model derived from the gamma-cycle timing rules.
module tb_race_gamma_sequencer;

    localparam int N   = 2;
    localparam int TW  = 3;
    localparam int INF = 7;

    logic          aclk;
    logic          grst;
    logic          in_valid;
    logic [N*TW-1:0] in_time;
    logic          out_ready;
    logic          force_job;

    logic          rdy_r, set_r, q_r, ov_r, err_r;
    logic [N-1:0]  edge_r;
    logic [TW-1:0] ot_r;
    logic          rdy_f, set_f, q_f, ov_f, err_f;
    logic [N-1:0]  edge_f;
    logic [TW-1:0] ot_f;

    int n_checks = 0;
    int n_fails  = 0;
    bit chk_en   = 1'b0;

    // Behavioural model: job phase by cycle age since accept.
    logic m_busy;
    int   m_age;
    int   m_t [N];
    logic m_err;
    logic q_force;

    race_gamma_sequencer #(.N(N), .TW(TW), .FALLING(1'b0)) u_rise (
        .aclk(aclk), .grst(grst), .in_valid(in_valid), .in_ready(rdy_r),
        .in_time(in_time), .set(set_r), .edge_o(edge_r), .q_i(q_r),
        .out_valid(ov_r), .out_ready(out_ready), .out_time(ot_r), .err(err_r)
    );

    race_gamma_sequencer #(.N(N), .TW(TW), .FALLING(1'b1)) u_fall (
        .aclk(aclk), .grst(grst), .in_valid(in_valid), .in_ready(rdy_f),
        .in_time(in_time), .set(set_f), .edge_o(edge_f), .q_i(q_f),
        .out_valid(ov_f), .out_ready(out_ready), .out_time(ot_f), .err(err_f)
    );

    initial aclk = 1'b0;
    always #5 aclk = ~aclk;

    // Fabric: first arrival of any edge, optionally forced active in SET.
    assign q_force = force_job && m_busy && (m_age == 1);
    assign q_r = (|edge_r) | q_force;
    assign q_f = ~((|(~edge_f)) | q_force);

    function automatic int tmin(input int a, input int b);
        return (a < b) ? a : b;
    endfunction

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fails++;
            $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
        end
    endtask

    always @(posedge aclk or negedge grst) begin
        if (!grst) begin
            m_busy <= 1'b0;
            m_age  <= 0;
            m_err  <= 1'b0;
        end else if (!m_busy) begin
            if (in_valid) begin
                m_busy <= 1'b1;
                m_age  <= 1;
                m_err  <= 1'b0;
                for (int i = 0; i < N; i++) m_t[i] <= int'(in_time[i*TW +: TW]);
            end
        end else begin
            if (m_age == 1) m_err <= q_force;
            if (m_age >= INF + 2) begin
                if (out_ready) m_busy <= 1'b0;
            end else begin
                m_age <= m_age + 1;
            end
        end
    end

    task automatic check_dut(input string id, input logic rdy, input logic st,
                             input logic [N-1:0] eact, input logic ov,
                             input logic [TW-1:0] ot, input logic er);
        bit            in_set, in_run, in_done;
        int            k;
        logic [N-1:0]  exp_e;
        in_set  = m_busy && (m_age == 1);
        in_run  = m_busy && (m_age >= 2) && (m_age <= INF + 1);
        in_done = m_busy && (m_age >= INF + 2);
        k = m_age - 2;
        for (int i = 0; i < N; i++)
            exp_e[i] = (in_run && (m_t[i] <= k)) || (in_done && (m_t[i] != INF));
        chk({id, " in_ready"}, rdy, !m_busy);
        chk({id, " set"}, st, in_set);
        chk({id, " edge"}, eact, exp_e);
        chk({id, " out_valid"}, ov, in_done);
        if (!in_set && !in_run) begin
            chk({id, " out_time"}, ot, in_done ? tmin(m_t[0], m_t[1]) : INF);
            chk({id, " err"}, er, in_done ? m_err : 1'b0);
        end
    endtask

    // Compare both DUTs to the model on every cycle.
    always @(negedge aclk) begin
        if (chk_en) begin
            check_dut("rise", rdy_r, set_r, edge_r, ov_r, ot_r, err_r);
            check_dut("fall", rdy_f, set_f, ~edge_f, ov_f, ot_f, err_f);
        end
    end

    task automatic run_job(input int a, input int b, input bit frc, input int hold,
                           input int exp_t, input bit exp_e);
        int            cyc;
        logic [TW-1:0] held_r;
        @(negedge aclk);
        in_time   = {b[TW-1:0], a[TW-1:0]};
        in_valid  = 1'b1;
        force_job = frc;
        @(negedge aclk);
        in_valid = 1'b0;
        cyc = 1;
        while (!(ov_r && ov_f) && cyc < 40) begin
            @(negedge aclk);
            cyc++;
        end
        $display("job a=%0d b=%0d force=%0d: latency=%0d out_time r/f=%0d/%0d err r/f=%0d/%0d",
                 a, b, frc, cyc, ot_r, ot_f, err_r, err_f);
        chk("latency", cyc, 9);
        chk("job out_time rise", ot_r, exp_t);
        chk("job out_time fall", ot_f, exp_t);
        chk("job err rise", err_r, exp_e);
        chk("job err fall", err_f, exp_e);
        if (hold > 0) begin
            held_r   = ot_r;
            in_valid = 1'b1;
            in_time  = ~in_time;
            repeat (hold) begin
                @(negedge aclk);
                chk("hold out_valid", ov_r, 1'b1);
                chk("hold out_time", ot_r, held_r);
            end
            in_valid = 1'b0;
        end
        out_ready = 1'b1;
        @(negedge aclk);
        out_ready = 1'b0;
        force_job = 1'b0;
        chk("post edge rise", edge_r, 2'b00);
        chk("post edge fall", edge_f, 2'b11);
        chk("post in_ready", rdy_r, 1'b1);
    endtask

    task automatic reset_mid_run();
        @(negedge aclk);
        in_time  = {3'd5, 3'd2};
        in_valid = 1'b1;
        @(negedge aclk);
        in_valid = 1'b0;
        repeat (4) @(negedge aclk);
        #2;
        grst = 1'b0;
        #1;
        $display("reset mid-run: out_valid=%0d edge r/f=%b/%b out_time=%0d", ov_r, edge_r, edge_f, ot_r);
        chk("rst out_valid", ov_r | ov_f, 1'b0);
        chk("rst set", set_r | set_f, 1'b0);
        chk("rst in_ready", rdy_r & rdy_f, 1'b1);
        chk("rst edge rise", edge_r, 2'b00);
        chk("rst edge fall", edge_f, 2'b11);
        chk("rst out_time", ot_r, INF);
        repeat (2) @(negedge aclk);
        grst = 1'b1;
        repeat (12) begin
            @(negedge aclk);
            chk("rst no result", ov_r | ov_f, 1'b0);
        end
    endtask

    initial begin
        int a, b, h;
        bit f;
        grst      = 1'b1;
        in_valid  = 1'b0;
        in_time   = '0;
        out_ready = 1'b0;
        force_job = 1'b0;
        #1;
        grst = 1'b0;
        repeat (2) @(negedge aclk);
        chk("reset out_time", ot_r, INF);
        chk("reset out_valid", ov_r | ov_f, 1'b0);
        chk("reset in_ready", rdy_r & rdy_f, 1'b1);
        chk("reset edge rise", edge_r, 2'b00);
        chk("reset edge fall", edge_f, 2'b11);
        chk("reset err", err_r | err_f, 1'b0);
        grst   = 1'b1;
        chk_en = 1'b1;

        run_job(2, 5, 1'b0, 0, 2, 1'b0);
        run_job(4, 1, 1'b0, 0, 1, 1'b0);
        run_job(3, 3, 1'b0, 0, 3, 1'b0);
        run_job(7, 7, 1'b0, 0, 7, 1'b0);
        run_job(0, 6, 1'b1, 0, 0, 1'b1);
        run_job(2, 5, 1'b0, 0, 2, 1'b0);
        run_job(1, 6, 1'b0, 5, 1, 1'b0);
        reset_mid_run();

        for (int j = 0; j < 12; j++) begin
            a = $urandom_range(0, INF);
            b = $urandom_range(0, INF);
            f = ($urandom_range(0, 3) == 0);
            h = $urandom_range(0, 3);
            run_job(a, b, f, h, tmin(a, b), f);
        end

        @(negedge aclk);
        chk_en = 1'b0;
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fails);
        $finish;
    end

endmodule

// File: doc/race_gamma_sequencer.md
# race_gamma_sequencer

Sequences one race-logic evaluation (a "gamma cycle") on a temporal primitive fabric such as a min/exclusive-min column. It accepts binary spike times via a valid/ready handshake and clears the fabric with a one-cycle `set` pulse. It then replays each time as an edge transition on a shared time base, samples the fabric output to measure its edge time, and returns that time as a binary result via valid/ready.

## Interface
- `N`, 2: number of temporal inputs driven into the fabric.
- `TW`, 3: time-value width; `INF = 2**TW-1` (all ones) encodes "no spike"; legal finite times are 0..INF-1.
- `FALLING`, 0: 0 means edges idle low and rise at the spike time; 1 means edges idle high and fall.
- `aclk` input 1: clock; all state updates on rising edge.
- `grst` input 1: reset; asynchronous assert, active-low, synchronous deassert assumed upstream.
- `in_valid` input 1: input times valid.
- `in_ready` output 1: sequencer can accept a job.
- `in_time` input N*TW: packed spike times; input i occupies bits [i*TW +: TW].
- `set` output 1: fabric clear pulse.
- `edge_o` output N: edge-coded spikes to the fabric.
- `q_i` input 1: fabric output, same polarity as `edge_o`; treated as synchronous to `aclk` and sampled each cycle.
- `out_valid` output 1: result valid.
- `out_ready` input 1: consumer accepts result.
- `out_time` output TW: measured fabric output time; INF if no edge.
- `err` output 1: fabric-not-cleared flag, valid with `out_valid`.

## Operation
- FSM states: IDLE, SET, RUN, DONE.
- IDLE:
  - `in_ready=1`; `edge_o` at idle level.
  - On `in_valid && in_ready`, latch `in_time` and go to SET.
- SET (exactly 1 cycle):
  - `set=1`; `edge_o` at idle level.
  - Sample `q_i`; if it is at its active level, set the internal err bit.
  - Go to RUN with `tcnt=0`.
- RUN (exactly INF cycles, `tcnt` = 0..INF-1):
  - `edge_o[i]` is active in the RUN cycle where `tcnt == t_i` and every later cycle. It is registered, so it transitions at the start of that cycle.
  - An input with `t_i == INF` never goes active.
  - `q_i` is sampled at the end of each RUN cycle. On the first cycle it is active, capture `out_time = tcnt` (first-edge wins; later toggles are ignored).
  - After `tcnt == INF-1`, go to DONE. There is no early exit; gamma length is fixed and deterministic.
- DONE:
  - `out_valid=1`; `out_time` = captured time, or INF if none was captured; `err` = latched bit.
  - `edge_o` holds its RUN levels.
  - Outputs are stable while `out_ready=0`.
  - On `out_ready`, go to IDLE; `edge_o` returns to idle level and the err bit clears.
- Duplicate times (`t_i == t_j`) are legal: both edges activate in the same cycle.
- `in_valid` outside IDLE is ignored, since `in_ready=0`.
- Arithmetic: `tcnt` is TW bits, counts up only, and never wraps within a job. Time comparison is unsigned equality/latch.

## Timing
- Reset values: FSM IDLE; `in_ready=1`; `set=0`; `edge_o` = all 0 (FALLING=0) or all 1 (FALLING=1); `out_valid=0`; `out_time=INF`; `err=0`; `tcnt=0`.
- Reset asserted mid-job aborts immediately, with all outputs at reset values the same cycle (asynchronous). No partial result is emitted.
- Latency from the accept edge (cycle 0):
  - `set` high in cycle 1.
  - RUN in cycles 2..INF+1.
  - `out_valid` first high in cycle INF+2 (cycle 9 for TW=3).
- Throughput is one job per INF+3 cycles with zero backpressure. `in_ready` rises the cycle after the DONE handshake.

## Structure
- Package `race_seq_pkg`:
  - state enum `seq_state_t` {IDLE, SET, RUN, DONE};
  - function `inf_time(TW)`;
  - edge idle-level helper `edge_idle(FALLING)`.
- Sub-module `spike_edge_gen`, instantiated N times, holds:
  - the latched time;
  - comparison against the shared `tcnt`;
  - a sticky "fired" flop;
  - polarity XOR.
- Top level holds the FSM, `tcnt`, `q_i` capture logic and handshakes.

## Test plan
The bench models the fabric as `q_i` = first-arrival of `edge_o`: OR for rising, AND for falling. Defaults are N=2 and TW=3.

- Times a=2, b=5 -> `edge_o[0]` active at RUN cycle 2, `edge_o[1]` at 5; `out_time=2`; `out_valid` at cycle 9 after accept.
- Times a=4, b=1, then a=3, b=3 -> `out_time=1`, then `out_time=3` with both edges activating in the same cycle.
- Both times = 7 (INF) -> no edge activates; `out_time=7`; `err=0`.
- Bench forces `q_i` active during SET, times a=0, b=6 -> `err=1`, `out_time=0`; next job with a clean fabric shows `err=0`.
- Hold `out_ready=0` for 5 cycles in DONE -> `out_valid`/`out_time` stable, new `in_valid` ignored; release -> IDLE, `edge_o` back to idle level.
- Assert `grst` low at RUN cycle 3, then repeat all cases with FALLING=1 -> reset values immediately, no `out_valid`; falling variant gives identical `out_time` values.
